// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: grant side of the DMA BR/BG handshake.
// Lets an in-flight CPU access finish and then grants the shared memory port
// to the DMA controller. On the DMA completion interrupt it returns the port
// to the CPU and pulses dma_done.
//
// Optional feature macro: DMA_TIMEOUT_EN. When it is defined, a grant that
// lasts TIMEOUT_CYCLES cycles without an interrupt is forced to release and
// sets timeout_err, which stays set until reset.
//
// Ports:
//   CLK, reset_n                    clock, synchronous active-low reset
//   BR, dma_interrupt               DMA request / transfer-complete
//   dma_write, dma_addr, dma_data   DMA 4-word write path
//   cpu_mem_req, cpu_mem_write,
//   cpu_addr, cpu_wdata             CPU single-word access path
//   BG                              registered bus grant
//   cpu_stall                       CPU must hold its access
//   mem_write, mem_burst,
//   mem_addr, mem_wdata             steered memory port
//   dma_done                        one-cycle pulse on a normal release
//   timeout_err                     sticky forced-release flag
module dma_bus_arbiter #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   BR,
  input  logic                   dma_interrupt,
  input  logic                   dma_write,
  input  logic [WORD_SIZE-1:0]   dma_addr,
  input  logic [4*WORD_SIZE-1:0] dma_data,
  input  logic                   cpu_mem_req,
  input  logic                   cpu_mem_write,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic                   BG,
  output logic                   cpu_stall,
  output logic                   mem_write,
  output logic                   mem_burst,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  output logic                   dma_done,
  output logic                   timeout_err
);

  localparam int unsigned BUS_W = 4 * WORD_SIZE;

  // Elaboration-time guard on the timeout parameter.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dma_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_n;
  logic   done_n;

`ifdef DMA_TIMEOUT_EN
  localparam logic [WORD_SIZE-1:0] TMO_LAST = WORD_SIZE'(TIMEOUT_CYCLES - 1);

  logic [WORD_SIZE-1:0] grant_cnt;
  logic                 tmo_hit;
  logic                 tmo_err_q;
`endif

  // Next-state and done-pulse decode; interrupt outranks timeout and abort.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
`ifdef DMA_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (BR) state_n = cpu_mem_req ? DRAIN : GRANT;
      end
      DRAIN: begin
        state_n = BR ? GRANT : IDLE;
      end
      GRANT: begin
        if (dma_interrupt) begin
          state_n = RELEASE;
          done_n  = 1'b1;
        end
`ifdef DMA_TIMEOUT_EN
        else if (grant_cnt == TMO_LAST) begin
          state_n = RELEASE;
          tmo_hit = 1'b1;
        end
`endif
        else if (!BR) begin
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!BR) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, grant and done registers.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state    <= IDLE;
      BG       <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state    <= state_n;
      BG       <= (state_n == GRANT);
      dma_done <= done_n;
    end
  end

`ifdef DMA_TIMEOUT_EN
  // Grant residency counter (clears on entry, saturates) and sticky error.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      grant_cnt <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_n == GRANT && state != GRANT) begin
        grant_cnt <= '0;
      end else if (state == GRANT && grant_cnt != '1) begin
        grant_cnt <= grant_cnt + WORD_SIZE'(1);
      end
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Memory port steering from the registered state; a stalled CPU write is
  // suppressed so it cannot reach memory while the DMA owns or is leaving the bus.
  always_comb begin
    cpu_stall = cpu_mem_req & ((state == GRANT) | (state == RELEASE));
    if (state == GRANT) begin
      mem_write = dma_write;
      mem_burst = 1'b1;
      mem_addr  = dma_addr;
      mem_wdata = dma_data;
    end else begin
      mem_write = cpu_mem_req & cpu_mem_write & ~cpu_stall;
      mem_burst = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = BUS_W'(cpu_wdata);
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural ownership model.
module tb_dma_bus_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 8;
`ifdef DMA_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           reset_n = 1'b0;
  logic           BR = 1'b0;
  logic           dma_interrupt = 1'b0;
  logic           dma_write = 1'b0;
  logic [W-1:0]   dma_addr = '0;
  logic [4*W-1:0] dma_data = '0;
  logic           cpu_mem_req = 1'b0;
  logic           cpu_mem_write = 1'b0;
  logic [W-1:0]   cpu_addr = '0;
  logic [W-1:0]   cpu_wdata = '0;
  logic           BG, cpu_stall, mem_write, mem_burst, dma_done, timeout_err;
  logic [W-1:0]   mem_addr;
  logic [4*W-1:0] mem_wdata;

  dma_bus_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .reset_n(reset_n), .BR(BR), .dma_interrupt(dma_interrupt),
    .dma_write(dma_write), .dma_addr(dma_addr), .dma_data(dma_data),
    .cpu_mem_req(cpu_mem_req), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .BG(BG), .cpu_stall(cpu_stall), .mem_write(mem_write), .mem_burst(mem_burst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dma_done(dma_done),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Behavioural model: who owns the bus and what is pending.
  bit dma_owns;     // DMA holds the port
  bit cpu_finishing; // one cycle for the CPU access in flight when BR arrived
  bit waiting_br_low; // grant withdrawn, waiting for BR to go away
  bit exp_done;
  bit exp_err;
  int grant_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      dma_owns = 0; cpu_finishing = 0; waiting_br_low = 0;
      exp_done = 0; exp_err = 0; grant_len = 0;
    end else begin
      exp_done = 0;
      if (dma_owns) begin
        grant_len++;
        if (dma_interrupt) begin
          dma_owns = 0; waiting_br_low = 1; exp_done = 1;
        end else if (TMO_EN && grant_len == TMO) begin
          dma_owns = 0; waiting_br_low = 1; exp_err = 1;
        end else if (!BR) begin
          dma_owns = 0; waiting_br_low = 1;
        end
      end else if (waiting_br_low) begin
        if (!BR) waiting_br_low = 0;
      end else if (cpu_finishing) begin
        cpu_finishing = 0;
        if (BR) begin dma_owns = 1; grant_len = 0; end
      end else if (BR) begin
        if (cpu_mem_req) cpu_finishing = 1;
        else begin dma_owns = 1; grant_len = 0; end
      end
    end
  endtask

  task automatic compare_all();
    logic stall;
    stall = cpu_mem_req & (dma_owns | waiting_br_low);
    check("BG", 64'(BG), 64'(dma_owns));
    check("cpu_stall", 64'(cpu_stall), 64'(stall));
    check("dma_done", 64'(dma_done), 64'(exp_done));
    check("timeout_err", 64'(timeout_err), 64'(exp_err));
    if (dma_owns) begin
      check("mem_write", 64'(mem_write), 64'(dma_write));
      check("mem_burst", 64'(mem_burst), 64'd1);
      check("mem_addr", 64'(mem_addr), 64'(dma_addr));
      check("mem_wdata", mem_wdata, dma_data);
    end else begin
      check("mem_write", 64'(mem_write), 64'(cpu_mem_req & cpu_mem_write & ~stall));
      check("mem_burst", 64'(mem_burst), 64'd0);
      check("mem_addr", 64'(mem_addr), 64'(cpu_addr));
      check("mem_wdata", mem_wdata, 64'(cpu_wdata));
    end
  endtask

  // One rising edge, update the model, then compare on the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    tick(); tick();
    check("rst_BG", 64'(BG), 64'd0);
    check("rst_done", 64'(dma_done), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);

    // Idle CPU grant: 1-cycle latency, DMA burst steering
    reset_n = 1'b1;
    BR = 1'b1; dma_write = 1'b1; dma_addr = 16'h01F4; dma_data = 64'h0001_0002_0003_0004;
    tick();
    check("idle_grant_BG", 64'(BG), 64'd1);
    check("idle_grant_addr", 64'(mem_addr), 64'h01F4);
    check("idle_grant_burst", 64'(mem_burst), 64'd1);
    check("idle_grant_data", mem_wdata, 64'h0001_0002_0003_0004);

    // CPU read during grant stalls; interrupt releases with one done pulse
    cpu_mem_req = 1'b1; cpu_mem_write = 1'b0; cpu_addr = 16'h0020;
    #1;
    check("grant_stall", 64'(cpu_stall), 64'd1);
    check("grant_addr_dma", 64'(mem_addr), 64'h01F4);
    dma_interrupt = 1'b1;
    tick();
    dma_interrupt = 1'b0;
    check("intr_BG", 64'(BG), 64'd0);
    check("intr_done", 64'(dma_done), 64'd1);
    tick();
    check("done_one_cycle", 64'(dma_done), 64'd0);
    check("release_stall", 64'(cpu_stall), 64'd1);
    check("release_no_regrant", 64'(BG), 64'd0);
    BR = 1'b0;
    tick();
    check("idle_unstall", 64'(cpu_stall), 64'd0);

    // BR during CPU write: write forwarded, DRAIN, BG after second edge
    BR = 1'b1; cpu_mem_req = 1'b1; cpu_mem_write = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    #1;
    check("drain_cpu_write", 64'(mem_write), 64'd1);
    check("drain_cpu_addr", 64'(mem_addr), 64'h0010);
    check("drain_cpu_data", mem_wdata, 64'h0000_0000_0000_BEEF);
    tick();
    cpu_mem_req = 1'b0;
    check("drain_BG_low", 64'(BG), 64'd0);
    tick();
    check("drain_BG_high", 64'(BG), 64'd1);

    // Abort with BR low, then BR high through RELEASE is not re-granted
    BR = 1'b0;
    tick();
    check("abort_BG", 64'(BG), 64'd0);
    check("abort_no_done", 64'(dma_done), 64'd0);
    BR = 1'b1;
    tick(); tick();
    check("held_br_no_regrant", 64'(BG), 64'd0);
    BR = 1'b0;
    tick();
    BR = 1'b1;
    tick();
    check("regrant_after_idle", 64'(BG), 64'd1);

    // Reset mid-grant
    reset_n = 1'b0;
    tick();
    check("midrst_BG", 64'(BG), 64'd0);
    check("midrst_done", 64'(dma_done), 64'd0);
    check("midrst_burst", 64'(mem_burst), 64'd0);
    reset_n = 1'b1; BR = 1'b0;
    tick();

    // Long grant with no interrupt
    BR = 1'b1;
    tick();
`ifdef DMA_TIMEOUT_EN
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    check("tmo_still_granted", 64'(BG), 64'd1);
    tick();
    check("tmo_BG_drop", 64'(BG), 64'd0);
    check("tmo_err_set", 64'(timeout_err), 64'd1);
    check("tmo_no_done", 64'(dma_done), 64'd0);
    BR = 1'b0;
    tick(); tick();
    check("tmo_err_sticky", 64'(timeout_err), 64'd1);
`else
    for (int i = 0; i < 100; i++) tick();
    check("no_tmo_BG_held", 64'(BG), 64'd1);
    check("no_tmo_err", 64'(timeout_err), 64'd0);
    BR = 1'b0;
    tick(); tick();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 5) == 0) BR = ~BR;
      dma_interrupt = ($urandom_range(0, 9) == 0);
      dma_write     = 1'($urandom);
      dma_addr      = W'($urandom);
      dma_data      = {32'($urandom), 32'($urandom)};
      cpu_mem_req   = 1'($urandom);
      cpu_mem_write = 1'($urandom);
      cpu_addr      = W'($urandom);
      cpu_wdata     = W'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
